int_sekwencer: RTL and testbench
================================

# int_sekwencer

Interrupt entry/exit sequencer between the `przerwanie` interrupt unit and the CPU core. It acts at instruction boundaries:
- On a pending request, it stalls the core, pushes the return PC and flags onto an internal shadow stack, disables interrupts and loads the vector into the PC.
- On RETI, it pops the stack, restores PC and flags, and re-enables interrupts.

Nested interrupts (software SEI inside an ISR) are supported up to `DEPTH` levels.

## Interface
Parameters:
- `PC_W`, 8, program counter width (≥ 8)
- `FLAG_W`, 4, ALU flag register width
- `DEPTH`, 4, shadow stack entries (≥ 1)

Ports:
- `clk`  in  1  clock; all state on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `przerwanie`  in  1  pending interrupt request (level, already enable-gated by interrupt unit)
- `int_vector`  in  8  handler address for pending request
- `instr_done`  in  1  core retires an instruction this cycle (boundary)
- `reti`  in  1  retiring instruction is RETI; qualified by `instr_done`
- `pc_next`  in  PC_W  address of next sequential instruction; qualified by `instr_done`
- `flags`  in  FLAG_W  ALU flags after retiring instruction; qualified by `instr_done`
- `stall`  out  1  core must not start a new instruction
- `pc_load`  out  1  one-cycle strobe: core PC <= `pc_new`
- `pc_new`  out  PC_W  PC load value
- `flags_load`  out  1  one-cycle strobe: core flags <= `flags_new`
- `flags_new`  out  FLAG_W  flag restore value
- `int_disable`  out  1  one-cycle pulse to interrupt unit (CLI)
- `int_enable`  out  1  one-cycle pulse to interrupt unit (SEI)
- `in_isr`  out  1  `depth != 0`
- `depth`  out  $clog2(DEPTH+1)  current stack occupancy
- `ovf_err`  out  1  sticky: request refused because stack was full
- `unf_err`  out  1  sticky: RETI with empty stack

## Operation
- FSM states: IDLE, SAVE, JUMP, RESTORE. Outputs are Moore, decoded from state and registers. `stall = (state != IDLE)`.
- IDLE, `instr_done & reti`:
  - `depth > 0`: go to RESTORE.
  - `depth == 0`: set `unf_err` and stay IDLE. The RETI behaves as a NOP: no pulses, no loads.
- IDLE, `instr_done & ~reti & przerwanie`:
  - `depth < DEPTH`: latch `pc_next`, `flags`, `int_vector`; go to SAVE.
  - `depth == DEPTH`: set `ovf_err`, stay IDLE, leave the request pending.
- RETI has priority over a simultaneous `przerwanie`. The request is taken at a later boundary if still pending.
- SAVE: push {latched pc, latched flags} at index `depth`; `depth` +1; `int_disable` = 1; go to JUMP.
- JUMP: `pc_load` = 1, `pc_new` = `int_vector` zero-extended to PC_W; go to IDLE.
- RESTORE:
  - Pop top entry; `depth` −1.
  - `pc_load` = `flags_load` = `int_enable` = 1; `pc_new`/`flags_new` = popped values.
  - Go to IDLE.
- `instr_done` is ignored while `stall` = 1. Core contract: it does not assert it then.
- Stack is LIFO, indexed by `depth`; no wrap-around. Entries are not cleared on pop.
- `ovf_err`/`unf_err` clear only on reset.
- Reset (any time, including mid-SAVE/JUMP/RESTORE):
  - Asynchronous return to IDLE; `depth` = 0; errors = 0.
  - `pc_new` = 0, `flags_new` = 0; all strobes/pulses = 0; `stall` = 0.
  - No pending load completes.

## Timing
- Entry, boundary at cycle T:
  - SAVE at T+1: `stall`, `int_disable`.
  - JUMP at T+2: `stall`, `pc_load`.
  - IDLE at T+3.
  - Latency from boundary to vector load is 2 cycles; stall length is 2 cycles.
- Exit, RETI boundary at T: RESTORE at T+1 (`stall`, `pc_load`, `flags_load`, `int_enable`); IDLE at T+2.
- `depth` and `in_isr` update on the edge leaving SAVE/RESTORE: visible from T+2 on entry, T+2 on exit.
- All pulses are exactly one cycle wide. `pc_new` holds its last value when `pc_load` = 0.
- Back-to-back: with `przerwanie` high at the first boundary after RESTORE, entry restarts immediately (T+2 boundary → SAVE at T+3).

## Test plan
- Reset: drive `rst` = 1 mid-JUMP → all outputs 0 immediately (async), `depth` = 0, no `pc_load` afterwards.
- Single entry/exit:
  - `przerwanie` = 1, `int_vector` = 0xFA, `pc_next` = 0x23, `flags` = 0x5 at boundary T.
  - Expect `int_disable` at T+1; `pc_load` with `pc_new` = 0xFA at T+2; `depth` = 1.
  - Later RETI boundary → `pc_new` = 0x23, `flags_new` = 0x5, `int_enable` pulse, `depth` = 0.
- Nesting: enter with vector 0xFA (pc 0x10), then enter with 0xFC (pc 0xFB) → `depth` = 2. Two RETIs return 0xFB, then 0x10, in order.
- Simultaneous RETI + `przerwanie` at depth 1 → RESTORE first. The next boundary with `przerwanie` = 1 enters SAVE.
- Overflow, DEPTH = 4: fifth request at `depth` = 4 → `ovf_err` = 1, no stall, `depth` stays 4. Pops still return the correct 4 PCs.
- Underflow: RETI at `depth` = 0 → `unf_err` = 1, no `pc_load`, no `int_enable`. `instr_done` during stall is ignored.

Source files
------------

// File: rtl/int_sekwencer.sv
// Interrupt entry/exit sequencer: saves PC/flags on a shadow stack at instruction
// boundaries, vectors to the handler, and restores state on RETI.
module int_sekwencer #(
  parameter int PC_W   = 8,
  parameter int FLAG_W = 4,
  parameter int DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         przerwanie,
  input  logic [7:0]                   int_vector,
  input  logic                         instr_done,
  input  logic                         reti,
  input  logic [PC_W-1:0]              pc_next,
  input  logic [FLAG_W-1:0]            flags,
  output logic                         stall,
  output logic                         pc_load,
  output logic [PC_W-1:0]              pc_new,
  output logic                         flags_load,
  output logic [FLAG_W-1:0]            flags_new,
  output logic                         int_disable,
  output logic                         int_enable,
  output logic                         in_isr,
  output logic [$clog2(DEPTH+1)-1:0]   depth,
  output logic                         ovf_err,
  output logic                         unf_err
);

  // state   | meaning
  // IDLE    | running; decide at each boundary (RETI pop / interrupt push)
  // SAVE    | push latched pc/flags, pulse int_disable
  // JUMP    | load vector into core PC
  // RESTORE | load popped pc/flags, pulse int_enable, shrink stack
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SAVE    = 2'd1;
  localparam logic [1:0] JUMP    = 2'd2;
  localparam logic [1:0] RESTORE = 2'd3;

  localparam int DW    = $clog2(DEPTH + 1);
  localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SLOTS = 1 << IW;
  localparam logic [DW-1:0] DEPTH_MAX = DW'(DEPTH);

  logic [1:0]        state;
  logic [PC_W-1:0]   lat_pc;
  logic [FLAG_W-1:0] lat_flags;
  logic [7:0]        lat_vec;
  logic [PC_W-1:0]   vec_ext;
  logic [DW-1:0]     depth_m1;
  logic [IW-1:0]     top_idx;
  logic [IW-1:0]     push_idx;

  logic [PC_W-1:0]   stack_pc [SLOTS];
  logic [FLAG_W-1:0] stack_fl [SLOTS];

  assign depth_m1 = depth - 1'b1;
  assign top_idx  = depth_m1[IW-1:0];
  assign push_idx = depth[IW-1:0];

  always_comb begin
    vec_ext      = '0;
    vec_ext[7:0] = lat_vec;
  end

  // pc_new/flags_new are registered so they are valid throughout JUMP/RESTORE
  // and hold their last value afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      depth     <= '0;
      ovf_err   <= 1'b0;
      unf_err   <= 1'b0;
      lat_pc    <= '0;
      lat_flags <= '0;
      lat_vec   <= '0;
      pc_new    <= '0;
      flags_new <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (instr_done) begin
            if (reti) begin
              if (depth != '0) begin
                pc_new    <= stack_pc[top_idx];
                flags_new <= stack_fl[top_idx];
                state     <= RESTORE;
              end else begin
                unf_err <= 1'b1;
              end
            end else if (przerwanie) begin
              if (depth < DEPTH_MAX) begin
                lat_pc    <= pc_next;
                lat_flags <= flags;
                lat_vec   <= int_vector;
                state     <= SAVE;
              end else begin
                ovf_err <= 1'b1;
              end
            end
          end
        end
        SAVE: begin
          depth  <= depth + 1'b1;
          pc_new <= vec_ext;
          state  <= JUMP;
        end
        JUMP: begin
          state <= IDLE;
        end
        RESTORE: begin
          depth <= depth_m1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stack storage needs no reset: occupancy is tracked by depth alone.
  always_ff @(posedge clk) begin
    if (state == SAVE) begin
      stack_pc[push_idx] <= lat_pc;
      stack_fl[push_idx] <= lat_flags;
    end
  end

  assign stall       = (state != IDLE);
  assign int_disable = (state == SAVE);
  assign pc_load     = (state == JUMP) || (state == RESTORE);
  assign flags_load  = (state == RESTORE);
  assign int_enable  = (state == RESTORE);
  assign in_isr      = (depth != '0);

endmodule

// File: tb/tb_int_sekwencer.sv
// Randomized bench for int_sekwencer against a queue-based LIFO model of
// interrupt entry/exit with cycle-accurate output expectations.
module tb_int_sekwencer;
  localparam int PC_W   = 8;
  localparam int FLAG_W = 4;
  localparam int DEPTH  = 4;
  localparam int DW     = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              rst;
  logic              przerwanie;
  logic [7:0]        int_vector;
  logic              instr_done;
  logic              reti;
  logic [PC_W-1:0]   pc_next;
  logic [FLAG_W-1:0] flags;
  logic              stall;
  logic              pc_load;
  logic [PC_W-1:0]   pc_new;
  logic              flags_load;
  logic [FLAG_W-1:0] flags_new;
  logic              int_disable;
  logic              int_enable;
  logic              in_isr;
  logic [DW-1:0]     depth;
  logic              ovf_err;
  logic              unf_err;

  int_sekwencer #(.PC_W(PC_W), .FLAG_W(FLAG_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .przerwanie(przerwanie), .int_vector(int_vector),
    .instr_done(instr_done), .reti(reti), .pc_next(pc_next), .flags(flags),
    .stall(stall), .pc_load(pc_load), .pc_new(pc_new), .flags_load(flags_load),
    .flags_new(flags_new), .int_disable(int_disable), .int_enable(int_enable),
    .in_isr(in_isr), .depth(depth), .ovf_err(ovf_err), .unf_err(unf_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // reference model: saved context as a LIFO plus last load values and sticky errors
  logic [PC_W-1:0]   m_pc [$];
  logic [FLAG_W-1:0] m_fl [$];
  logic [PC_W-1:0]   m_pcnew;
  logic [FLAG_W-1:0] m_fnew;
  logic              m_ovf;
  logic              m_unf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input string ph, input logic e_stall, input logic e_pl,
                          input logic e_fl, input logic e_dis, input logic e_en);
    chk({ph, ".stall"},       32'(stall),       32'(e_stall));
    chk({ph, ".pc_load"},     32'(pc_load),     32'(e_pl));
    chk({ph, ".flags_load"},  32'(flags_load),  32'(e_fl));
    chk({ph, ".int_disable"}, 32'(int_disable), 32'(e_dis));
    chk({ph, ".int_enable"},  32'(int_enable),  32'(e_en));
    chk({ph, ".pc_new"},      32'(pc_new),      32'(m_pcnew));
    chk({ph, ".flags_new"},   32'(flags_new),   32'(m_fnew));
    chk({ph, ".depth"},       32'(depth),       32'(m_pc.size()));
    chk({ph, ".in_isr"},      32'(in_isr),      32'(m_pc.size() != 0));
    chk({ph, ".ovf_err"},     32'(ovf_err),     32'(m_ovf));
    chk({ph, ".unf_err"},     32'(unf_err),     32'(m_unf));
  endtask

  task automatic model_reset();
    m_pc.delete();
    m_fl.delete();
    m_pcnew = '0;
    m_fnew  = '0;
    m_ovf   = 1'b0;
    m_unf   = 1'b0;
  endtask

  // random traffic while stalled; the sequencer must ignore all of it
  task automatic junk();
    instr_done = 1'($urandom_range(0, 1));
    reti       = 1'($urandom_range(0, 1));
    przerwanie = 1'($urandom_range(0, 1));
    int_vector = 8'($urandom);
    pc_next    = PC_W'($urandom);
    flags      = FLAG_W'($urandom);
  endtask

  task automatic quiet();
    instr_done = 1'b0;
    reti       = 1'($urandom_range(0, 1));
    przerwanie = 1'($urandom_range(0, 1));
    int_vector = 8'($urandom);
    pc_next    = PC_W'($urandom);
    flags      = FLAG_W'($urandom);
  endtask

  // One instruction boundary followed by the full expected response; called
  // and returning at a falling edge with the sequencer idle.
  task automatic boundary(input logic r, input logic p, input logic [7:0] v,
                          input logic [PC_W-1:0] pcn, input logic [FLAG_W-1:0] f);
    instr_done = 1'b1; reti = r; przerwanie = p;
    int_vector = v; pc_next = pcn; flags = f;
    @(negedge clk);
    if (r) begin
      if (m_pc.size() > 0) begin
        m_pcnew = m_pc[$];
        m_fnew  = m_fl[$];
        chk_outs("restore", 1, 1, 1, 0, 1);
        void'(m_pc.pop_back());
        void'(m_fl.pop_back());
        junk();
        @(negedge clk);
      end else begin
        m_unf = 1'b1;
      end
    end else if (p) begin
      if (m_pc.size() < DEPTH) begin
        chk_outs("save", 1, 0, 0, 1, 0);
        m_pc.push_back(pcn);
        m_fl.push_back(f);
        junk();
        @(negedge clk);
        m_pcnew = PC_W'(v);
        chk_outs("jump", 1, 1, 0, 0, 0);
        junk();
        @(negedge clk);
      end else begin
        m_ovf = 1'b1;
      end
    end
    chk_outs("idle", 0, 0, 0, 0, 0);
    quiet();
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      quiet();
      @(negedge clk);
      chk_outs("quiet", 0, 0, 0, 0, 0);
    end
  endtask

  task automatic reset_mid_jump(input logic [7:0] v, input logic [PC_W-1:0] pcn,
                                input logic [FLAG_W-1:0] f);
    instr_done = 1'b1; reti = 1'b0; przerwanie = 1'b1;
    int_vector = v; pc_next = pcn; flags = f;
    @(negedge clk);
    chk_outs("rst_save", 1, 0, 0, 1, 0);
    m_pc.push_back(pcn);
    m_fl.push_back(f);
    junk();
    @(negedge clk);
    m_pcnew = PC_W'(v);
    chk_outs("rst_jump", 1, 1, 0, 0, 0);
    #1 rst = 1'b1;
    #1 model_reset();
    chk_outs("rst_async", 0, 0, 0, 0, 0);
    @(negedge clk);
    chk_outs("rst_hold", 0, 0, 0, 0, 0);
    rst = 1'b0;
    quiet();
    @(negedge clk);
    chk_outs("rst_after", 0, 0, 0, 0, 0);
    @(negedge clk);
    chk_outs("rst_after2", 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1;
    quiet();
    model_reset();
    #2 chk_outs("por", 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_outs("por_idle", 0, 0, 0, 0, 0);

    // single entry / exit
    boundary(0, 1, 8'hFA, 8'h23, 4'h5);
    chk("single.vec_load", 32'(pc_new), 32'h0000_00FA);
    idle_cycles(2);
    boundary(1, 0, 8'h00, 8'h77, 4'hA);
    chk("single.ret_pc", 32'(pc_new), 32'h0000_0023);
    chk("single.ret_flags", 32'(flags_new), 32'h0000_0005);

    // nesting
    boundary(0, 1, 8'hFA, 8'h10, 4'h3);
    boundary(0, 1, 8'hFC, 8'hFB, 4'hC);
    chk("nest.depth", 32'(depth), 32'd2);
    boundary(1, 0, 8'h00, 8'h00, 4'h0);
    chk("nest.ret1", 32'(pc_new), 32'h0000_00FB);
    boundary(1, 0, 8'h00, 8'h00, 4'h0);
    chk("nest.ret2", 32'(pc_new), 32'h0000_0010);

    // RETI beats a simultaneous request; request taken at the following boundary
    boundary(0, 1, 8'h40, 8'h55, 4'h1);
    boundary(1, 1, 8'h41, 8'h66, 4'h2);
    boundary(0, 1, 8'h42, 8'h67, 4'h4);
    boundary(1, 0, 8'h00, 8'h00, 4'h0);

    // overflow then ordered pops, then underflow
    for (int i = 0; i < 5; i++)
      boundary(0, 1, 8'(8'h80 + i), PC_W'(8'h30 + i), FLAG_W'(i));
    chk("ovf.flag", 32'(ovf_err), 32'd1);
    chk("ovf.depth", 32'(depth), 32'(DEPTH));
    for (int i = 0; i < 4; i++)
      boundary(1, 0, 8'h00, 8'h00, 4'h0);
    boundary(1, 0, 8'h00, 8'h00, 4'h0);
    chk("unf.flag", 32'(unf_err), 32'd1);

    reset_mid_jump(8'hE0, 8'h12, 4'h9);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic r, p;
      r = ($urandom_range(0, 99) < 40);
      p = ($urandom_range(0, 99) < 65);
      if ($urandom_range(0, 9) == 0) idle_cycles(1);
      boundary(r, p, 8'($urandom), PC_W'($urandom), FLAG_W'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
